// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if -- consumer-side handshake bundle of the UART receiver.
//
// Parameters:
//   DATA_BITS   width of the received word (5..8)
//
// Signals:
//   rx_ack       consumer acknowledge, clears rx_valid
//   rx_data      last received word (LSB was first on the line)
//   rx_valid     level, high while rx_data holds an unacknowledged word
//   framing_err  stop bit of the rx_data frame was sampled low
//   parity_err   parity mismatch for the rx_data frame
//   overrun      one-cycle pulse, a frame completed while rx_valid was high
//
// Modports:
//   master  the receiver (drives the word and status, reads rx_ack)
//   slave   the consumer (drives rx_ack, reads the word and status)
// -----------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output framing_err,
    output parity_err,
    output overrun
  );

  modport slave (
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  framing_err,
    input  parity_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with valid/ack output handshake.
//
// Parameters:
//   OVERSAMPLING_RATE  baud_tick pulses per bit period (even, >= 4)
//   DATA_BITS          data bits per frame (5..8)
//   PARITY_ODD         0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   baud_tick  single-cycle enable at OVERSAMPLING_RATE x baud
//   rx         serial line, idle high, asynchronous to clk
//   bus        uart_rx_if.master: rx_ack in; rx_data, rx_valid,
//              framing_err, parity_err, overrun out
//
// Build option:
//   UART_RX_PARITY_EN  when defined, frames carry a parity bit between the
//                      data bits and the stop bit. When undefined the parity
//                      state is absent and parity_err is tied low.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLING_RATE = 16,
  parameter int DATA_BITS         = 8,
  parameter int PARITY_ODD        = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      baud_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TICK_W = $clog2(OVERSAMPLING_RATE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_M1  = TICK_W'(OVERSAMPLING_RATE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; both flops reset to the idle line level so reset
  // release never looks like a falling edge.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 armed_q;      // a high sample was seen since reset / last stop
  logic                 done_q;       // stop bit sampled last cycle
  logic                 ferr_pend_q;  // framing status of the frame just finished
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic                 perr_pend_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      ferr_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (baud_tick) begin
        case (state_q)
          S_IDLE: begin
            // A falling edge only counts once the line has been seen high,
            // so a stuck-low line after a bad stop bit or after reset
            // release cannot start a frame.
            if (rx_s_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q    <= S_START;
              tick_cnt_q <= '0;
            end
          end

          S_START: begin
            if (tick_cnt_q == HALF_M1) begin
              tick_cnt_q <= '0;
              if (rx_s_q) begin
                state_q <= S_IDLE;          // glitch shorter than half a bit
              end else begin
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          S_DATA: begin
            // tick_cnt is now aligned to mid-bit, so every full period lands
            // in the middle of the next bit.
            if (tick_cnt_q == FULL_M1) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt_q == FULL_M1) begin
              tick_cnt_q  <= '0;
              perr_pend_q <= (^shift_q) ^ rx_s_q ^ PAR_ODD;
              state_q     <= S_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif

          S_STOP: begin
            if (tick_cnt_q == FULL_M1) begin
              tick_cnt_q  <= '0;
              ferr_pend_q <= ~rx_s_q;
              done_q      <= 1'b1;
              armed_q     <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          default: begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word and handshake. Runs every cycle, independent of baud_tick.
  // Completion has priority over an acknowledge arriving in the same cycle:
  // the acknowledge is taken as consuming the old word, so no overrun.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 framing_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        rx_data_q     <= shift_q;
        rx_valid_q    <= 1'b1;
        framing_err_q <= ferr_pend_q;
`ifdef UART_RX_PARITY_EN
        parity_err_q  <= perr_pend_q;
`endif
        overrun_q     <= rx_valid_q & ~bus.rx_ack;
      end else if (bus.rx_ack && rx_valid_q) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.framing_err = framing_err_q;
  assign bus.overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = parity_err_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule
